ex_muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX register outputs (rs1/rs2 operands).

---
 rtl/ex_muldiv_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide for the EX stage.
// Holds the pipeline via stall_o until the single DONE cycle.
module ex_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   opd_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, rneg_q;

  logic [XLEN-1:0]   res_d;
  logic              res_we;
  logic              load;

  // operand decode, only meaningful in IDLE
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            is_div, div0, ovf;
  logic [XLEN-1:0] early_res;

  assign is_div = op_i[2];
  assign a_sgn  = rs1_i[XLEN-1] &
                  (op_i == 3'd1 || op_i == 3'd2 ||
                   op_i == 3'd4 || op_i == 3'd6);
  assign b_sgn  = rs2_i[XLEN-1] &
                  (op_i == 3'd1 || op_i == 3'd4 ||
                   op_i == 3'd6);
  assign mag_a  = a_sgn ? -rs1_i : rs1_i;
  assign mag_b  = b_sgn ? -rs2_i : rs2_i;
  assign div0   = is_div & (rs2_i == '0);
  assign ovf    = is_div & ~op_i[0] &
                  (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &
                  (rs2_i == '1);

  always_comb begin
    early_res = '0;
    if (div0)
      early_res = op_i[1] ? rs1_i : '1;
    else if (ovf)
      early_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // multiply step: acc = {partial, multiplier}
  logic [2*XLEN-1:0] mul_nxt;

  if (FAST_MUL) begin : g_fast
    assign mul_nxt = (2*XLEN)'(opd_q) *
                     (2*XLEN)'(acc_q[XLEN-1:0]);
  end else begin : g_seq
    logic [XLEN:0] sum;
    assign sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                 (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mul_nxt = {sum, acc_q[XLEN-1:1]};
  end

  // restoring divide step: acc = {rem, quo}
  logic [XLEN:0]     shl, trial;
  logic [2*XLEN-1:0] div_nxt;

  assign shl   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign trial = shl - {1'b0, opd_q};
  assign div_nxt = trial[XLEN] ?
    {shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
    {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res, div_res, quo, rem;

  assign prod_s  = neg_q ? -mul_nxt : mul_nxt;
  assign mul_res = (op_q == 3'd0) ? prod_s[XLEN-1:0] :
                                    prod_s[2*XLEN-1:XLEN];
  assign quo     = div_nxt[XLEN-1:0];
  assign rem     = div_nxt[2*XLEN-1:XLEN];
  assign div_res = op_q[1] ? (rneg_q ? -rem : rem) :
                             (neg_q ? -quo : quo);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = result_o;
    res_we  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (div0 | ovf) begin
            state_d = S_DONE;
            res_d   = early_res;
            res_we  = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = is_div ? S_DIV : S_MUL;
            cnt_d   = (FAST_MUL && !is_div) ?
                      '0 : CW'(XLEN-1);
          end
        end
      end
      S_MUL: begin
        acc_d = mul_nxt;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = mul_res;
          res_we  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        acc_d = div_nxt;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = div_res;
          res_we  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
    // flush wins over start and suppresses the result write
    if (flush_i) begin
      state_d = S_IDLE;
      res_we  = 1'b0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_o <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        op_q   <= op_i;
        opd_q  <= is_div ? mag_b : mag_a;
        acc_q  <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
        neg_q  <= a_sgn ^ b_sgn;
        rneg_q <= a_sgn;
      end else begin
        acc_q <= acc_d;
      end
      if (res_we) result_o <= res_d;
    end
  end

  assign busy_o  = (state_q == S_MUL) | (state_q == S_DIV);
  assign done_o  = (state_q == S_DONE);
  assign stall_o = busy_o |
                   ((state_q == S_IDLE) & start_i & ~flush_i);

endmodule
